// File: rtl/mc_control_fsm.sv
// ============================================================================
//  Module      : mc_control_fsm
//  Description : Multi-cycle MIPS control sequencer. Steps each instruction
//                through FETCH/DECODE/EXEC/MEM/WB, drives the datapath selects
//                and write enables, and talks to a shared memory port through
//                a req/ready handshake with a wait-state timeout and retry.
//                Optional macro MC_ILLEGAL_TRAP_EN: unknown opcodes enter a
//                sticky TRAP state and the illegal_op output is added.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control_fsm #(
    parameter int ALUOP_W     = 6,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic [1:0]         mem_size,
    output logic               mem_unsigned,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               imm_zext,
    output logic               lui,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               mem_timeout,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LB    = 6'h20;
    localparam logic [5:0] c_OP_LH    = 6'h21;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_LBU   = 6'h24;
    localparam logic [5:0] c_OP_LHU   = 6'h25;
    localparam logic [5:0] c_OP_SB    = 6'h28;
    localparam logic [5:0] c_OP_SH    = 6'h29;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // Counter only needs to reach MEM_TIMEOUT; keep at least one bit.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    logic [5:0]         op_q;
    logic [CNT_W-1:0]   wait_q, wait_d;

    logic w_mem_phase;
    logic w_timeout;
    logic w_req;
    logic w_accept;
    logic w_is_load;
    logic w_is_store;

    assign w_mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    // The timeout cycle withdraws the request, so mem_ready is ignored then.
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_phase && (wait_q == CNT_W'(MEM_TIMEOUT));
    assign w_req       = w_mem_phase && !w_timeout;
    assign w_accept    = w_req && mem_ready;
    // Only unanswered request cycles count; anything else restarts the count.
    assign wait_d      = ((MEM_TIMEOUT != 0) && w_req && !mem_ready) ? wait_q + 1'b1 : '0;

    assign w_is_load   = op_q inside {c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU};
    assign w_is_store  = op_q inside {c_OP_SB, c_OP_SH, c_OP_SW};

    // State, latched opcode and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Next-state and per-state datapath control decode.
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_size      = 2'd0;
        mem_unsigned  = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = '0;
        imm_zext      = 1'b0;
        lui           = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        mem_timeout   = w_timeout;
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_op    = 1'b0;
`endif
        state         = state_q;

        case (state_q)
            S_FETCH: begin
                mem_req   = w_req;
                alu_src_b = 2'd1;
                if (w_accept) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute PC + (imm << 2) for a possible branch.
                alu_src_b = 2'd3;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    c_OP_RTYPE: begin
                        alu_src_a = 1'b1;
                        alu_op    = ALUOP_W'(2);
                        state_d   = S_WB;
                    end
                    c_OP_ADDI, c_OP_ADDIU: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        state_d   = S_WB;
                    end
                    c_OP_ANDI, c_OP_ORI: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        imm_zext  = 1'b1;
                        alu_op    = ALUOP_W'(op_q);
                        state_d   = S_WB;
                    end
                    c_OP_SLTI, c_OP_SLTIU: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        alu_op    = ALUOP_W'(op_q);
                        state_d   = S_WB;
                    end
                    c_OP_LUI: begin
                        alu_src_b = 2'd2;
                        lui       = 1'b1;
                        alu_op    = ALUOP_W'(c_OP_LUI);
                        state_d   = S_WB;
                    end
                    c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU,
                    c_OP_SB, c_OP_SH, c_OP_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end
                    c_OP_BEQ, c_OP_BNE: begin
                        alu_src_a     = 1'b1;
                        alu_op        = ALUOP_W'(1);
                        pc_write_cond = 1'b1;
                        pc_src        = 2'd1;
                        branch_ne     = (op_q == c_OP_BNE);
                    end
                    c_OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                mem_req      = w_req;
                iord         = 1'b1;
                mem_we       = w_is_store && w_req;
                mem_unsigned = (op_q == c_OP_LBU) || (op_q == c_OP_LHU);
                case (op_q)
                    c_OP_LH, c_OP_LHU, c_OP_SH: mem_size = 2'd1;
                    c_OP_LW, c_OP_SW:           mem_size = 2'd2;
                    default:                    mem_size = 2'd0;
                endcase
                if (w_accept) begin
                    state_d = w_is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == c_OP_RTYPE);
                mem_to_reg = w_is_load;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
                illegal_op = 1'b1;
                state_d    = S_TRAP;
`else
                state_d    = S_FETCH;
`endif
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every output so a stalled access has no side effects.
        if (rst) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_size      = 2'd0;
            mem_unsigned  = 1'b0;
            iord          = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            branch_ne     = 1'b0;
            pc_src        = 2'd0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'd0;
            alu_op        = '0;
            imm_zext      = 1'b0;
            lui           = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            mem_timeout   = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_op    = 1'b0;
`endif
            state         = 3'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
//  Module      : tb_mc_control_fsm
//  Description : Self-checking bench for mc_control_fsm. A phase-route model
//                of the instruction sequence predicts every output each cycle
//                under directed and $urandom stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

    localparam int TO = 4;

    localparam int PH_F = 0;
    localparam int PH_D = 1;
    localparam int PH_E = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_T = 5;

    localparam int C_R = 0, C_ADDI = 1, C_LOGIC = 2, C_SLT = 3, C_LUI = 4;
    localparam int C_LOAD = 5, C_STORE = 6, C_BR = 7, C_J = 8, C_BAD = 9;

    typedef struct packed {
        logic       req;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic       bne;
        logic [1:0] pcsrc;
        logic       asrca;
        logic [1:0] asrcb;
        logic [5:0] aluop;
        logic       zext;
        logic       lui;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       to;
        logic       ill;
        logic [2:0] st;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_unsigned, iord, ir_write, pc_write;
    logic       pc_write_cond, branch_ne, alu_src_a, imm_zext, lui;
    logic       reg_write, reg_dst, mem_to_reg, mem_timeout;
    logic [1:0] mem_size, pc_src, alu_src_b;
    logic [5:0] alu_op;
    logic [2:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    mc_control_fsm #(.ALUOP_W(6), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_zext(imm_zext), .lui(lui), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_timeout(mem_timeout),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         m_phase = PH_F;
    int         m_wcnt = 0;
    logic [5:0] m_op = 6'h00;
    int         route[$];
    logic [5:0] op_plan[$];
    outs_t      obs;

    logic [5:0] op_table [23] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                  6'h0C, 6'h0D, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                                  6'h28, 6'h29, 6'h2B, 6'h03, 6'h3F, 6'h10, 6'h31};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'h00:                             return C_R;
            6'h08, 6'h09:                      return C_ADDI;
            6'h0C, 6'h0D:                      return C_LOGIC;
            6'h0A, 6'h0B:                      return C_SLT;
            6'h0F:                             return C_LUI;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return C_LOAD;
            6'h28, 6'h29, 6'h2B:               return C_STORE;
            6'h04, 6'h05:                      return C_BR;
            6'h02:                             return C_J;
            default:                           return C_BAD;
        endcase
    endfunction

    function automatic logic [1:0] access_size(input logic [5:0] op);
        case (op)
            6'h21, 6'h25, 6'h29: return 2'd1;
            6'h23, 6'h2B:        return 2'd2;
            default:             return 2'd0;
        endcase
    endfunction

    // What the control word should be for one cycle of a given phase.
    function automatic outs_t expected(input int ph, input logic [5:0] op,
                                       input logic rdy, input logic to, input logic r);
        outs_t e;
        int    c;
        e = '0;
        c = op_class(op);
        if (r) return e;
        e.st = 3'(ph);
        case (ph)
            PH_F: begin
                e.req   = !to;
                e.to    = to;
                e.asrcb = 2'd1;
                e.irw   = rdy && !to;
                e.pcw   = rdy && !to;
            end
            PH_D: e.asrcb = 2'd3;
            PH_E: begin
                case (c)
                    C_R:     begin e.asrca = 1; e.aluop = 6'd2; end
                    C_ADDI:  begin e.asrca = 1; e.asrcb = 2'd2; end
                    C_LOGIC: begin e.asrca = 1; e.asrcb = 2'd2; e.zext = 1; e.aluop = op; end
                    C_SLT:   begin e.asrca = 1; e.asrcb = 2'd2; e.aluop = op; end
                    C_LUI:   begin e.asrcb = 2'd2; e.lui = 1; e.aluop = 6'h0F; end
                    C_LOAD, C_STORE: begin e.asrca = 1; e.asrcb = 2'd2; end
                    C_BR:    begin
                        e.asrca = 1; e.aluop = 6'd1; e.pcwc = 1; e.pcsrc = 2'd1;
                        e.bne = (op == 6'h05);
                    end
                    C_J:     begin e.pcw = 1; e.pcsrc = 2'd2; end
                    default: ;
                endcase
            end
            PH_M: begin
                e.req  = !to;
                e.to   = to;
                e.iord = 1;
                e.we   = (c == C_STORE) && !to;
                e.size = access_size(op);
                e.uns  = (op == 6'h24) || (op == 6'h25);
            end
            PH_W: begin
                e.rw   = 1;
                e.rdst = (c == C_R);
                e.m2r  = (c == C_LOAD);
            end
            PH_T: e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.req = mem_req; o.we = mem_we; o.size = mem_size; o.uns = mem_unsigned;
        o.iord = iord; o.irw = ir_write; o.pcw = pc_write; o.pcwc = pc_write_cond;
        o.bne = branch_ne; o.pcsrc = pc_src; o.asrca = alu_src_a; o.asrcb = alu_src_b;
        o.aluop = alu_op; o.zext = imm_zext; o.lui = lui; o.rw = reg_write;
        o.rdst = reg_dst; o.m2r = mem_to_reg; o.to = mem_timeout; o.st = state;
`ifdef MC_ILLEGAL_TRAP_EN
        o.ill = illegal_op;
`else
        o.ill = 1'b0;
`endif
        return o;
    endfunction

    // Move to the next phase of the current instruction's route.
    task automatic advance();
        int c;
        if (m_phase == PH_F) begin
            if (op_plan.size() > 0) m_op = op_plan.pop_front();
            else                    m_op = op_table[$urandom_range(0, 22)];
            c = op_class(m_op);
            route.delete();
            route.push_back(PH_D);
            route.push_back(PH_E);
            if (c <= C_LUI) route.push_back(PH_W);
            if (c == C_LOAD) begin route.push_back(PH_M); route.push_back(PH_W); end
            if (c == C_STORE) route.push_back(PH_M);
`ifdef MC_ILLEGAL_TRAP_EN
            if (c == C_BAD) route.push_back(PH_T);
`endif
        end
        m_phase = (route.size() > 0) ? route.pop_front() : PH_F;
    endtask

    // One clock: drive inputs, compare full control word, step the model.
    task automatic tick(input logic r, input logic rdy);
        outs_t e;
        logic  to;
        @(negedge clk);
        rst       = r;
        mem_ready = rdy;
        opcode    = (m_phase == PH_D) ? m_op : 6'($urandom);
        #2;
        to  = (m_phase == PH_F || m_phase == PH_M) && (m_wcnt == TO);
        e   = expected(m_phase, m_op, rdy, to, r);
        obs = sample();
        check_val("cycle", {1'b0, obs}, {1'b0, e});
        if (r) begin
            m_phase = PH_F;
            m_wcnt  = 0;
            route.delete();
        end else if (m_phase == PH_F || m_phase == PH_M) begin
            if (to)       m_wcnt = 0;
            else if (rdy) begin m_wcnt = 0; advance(); end
            else          m_wcnt++;
        end else if (m_phase != PH_T) begin
            advance();
        end
    endtask

    // Run one instruction from FETCH and count cycles until the DUT shows FETCH again.
    task automatic run_instr(input logic [5:0] op, input int stall, input int want, input string tag);
        int   n;
        int   s;
        logic rd;
        logic seen0;
        s     = stall;
        seen0 = 1'b0;
        op_plan.push_back(op);
        tick(1'b0, 1'b1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            rd = 1'b1;
            if (m_phase == PH_M && s > 0) begin rd = 1'b0; s--; end
            if (m_phase == PH_F) rd = 1'b0;
            tick(1'b0, rd);
            if (obs.st == 3'd0) begin seen0 = 1'b1; break; end
            n++;
        end
        check_val(tag, seen0 ? 32'(n) : 32'd99, 32'(want));
    endtask

    initial begin
        int trap_cycles;
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'h00;
        trap_cycles = 0;

        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check_val("rst_state", 32'(obs.st), 32'd0);

        // Fetch timeout: four unanswered cycles, then a withdrawn-request pulse.
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check_val("to_pulse", {30'd0, obs.to, obs.req}, {30'd0, 1'b1, 1'b0});
        check_val("to_state", 32'(obs.st), 32'd0);
        tick(1'b0, 1'b0);
        check_val("to_reissue", {30'd0, obs.to, obs.req}, {30'd0, 1'b0, 1'b1});

        run_instr(6'h00, 0, 4, "lat_rtype");
        run_instr(6'h23, 3, 8, "lat_lw_stall");
        run_instr(6'h05, 0, 3, "lat_bne");
        run_instr(6'h04, 0, 3, "lat_beq");
        run_instr(6'h2B, 0, 4, "lat_sw");
        run_instr(6'h24, 0, 5, "lat_lbu");
        run_instr(6'h0D, 0, 4, "lat_ori");
        run_instr(6'h02, 0, 3, "lat_j");

        // Store stalled in MEM, then reset mid-access.
        op_plan.push_back(6'h28);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_val("sb_stall_we", {30'd0, obs.req, obs.we}, {30'd0, 1'b1, 1'b1});
        tick(1'b1, 1'b0);
        check_val("sb_rst_quiet", {29'd0, obs.req, obs.we, obs.rw}, 32'd0);
        tick(1'b0, 1'b0);
        check_val("sb_rst_fetch", 32'(obs.st), 32'd0);

`ifdef MC_ILLEGAL_TRAP_EN
        op_plan.push_back(6'h3F);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
        check_val("trap_hold", {28'd0, obs.ill, obs.st}, {28'd0, 1'b1, 3'd5});
        tick(1'b1, 1'b0);
        check_val("trap_rst_ill", 32'(obs.ill), 32'd0);
        tick(1'b0, 1'b0);
        check_val("trap_exit", 32'(obs.st), 32'd0);
`else
        run_instr(6'h3F, 0, 3, "lat_illegal_nop");
`endif

        // Random traffic: random ready, occasional reset, reset out of TRAP.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0) || (m_phase == PH_T && trap_cycles > 3),
                 ($urandom_range(0, 9) < 6));
            trap_cycles = (m_phase == PH_T) ? trap_cycles + 1 : 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
